// File: rtl/pattern0_checker.sv
// Receive-side checker for the repeating A6E2/F0A0/5CDB/475E training pattern.
// The checker finds the pattern phase, declares lock, counts word errors while locked, and requests a bitslip.
module pattern0_checker #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_ERR = 4,
    parameter int SLIP_WAIT  = 16,
    parameter int CNT_W      = 16
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [15:0]      i_DATA,
    input  logic             i_VALID,
    input  logic             i_CLR_ERR,
    output logic             o_LOCKED,
    output logic             o_ERR,
    output logic [CNT_W-1:0] o_ERR_CNT,
    output logic [1:0]       o_PHASE,
    output logic             o_SLIP
);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [7:0] LOCK_LIM   = 8'(LOCK_CNT);
    localparam logic [7:0] UNLOCK_LIM = 8'(UNLOCK_ERR);
    localparam logic [7:0] SLIP_LIM   = 8'(SLIP_WAIT);

    function automatic logic [15:0] pattern_word(input logic [1:0] idx);
        case (idx)
            2'd0:    pattern_word = 16'hA6E2;
            2'd1:    pattern_word = 16'hF0A0;
            2'd2:    pattern_word = 16'h5CDB;
            default: pattern_word = 16'h475E;
        endcase
    endfunction

    state_t           state, state_n;
    logic [1:0]       phase, phase_n;
    logic [7:0]       match_cnt, match_n;
    logic [7:0]       miss_cnt, miss_n;
    logic [7:0]       err_run, err_run_n;
    logic [CNT_W-1:0] err_cnt, err_cnt_n;
    logic             err_n, slip_n;
    logic             hit;
    logic [1:0]       hit_idx;
    logic             exp_match;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (!hit && i_DATA == pattern_word(2'(k))) begin
                hit     = 1'b1;
                hit_idx = 2'(k);
            end
        end
        exp_match = (i_DATA == pattern_word(phase));

        state_n   = state;
        phase_n   = phase;
        match_n   = match_cnt;
        miss_n    = miss_cnt;
        err_run_n = err_run;
        err_cnt_n = err_cnt;
        err_n     = 1'b0;
        slip_n    = 1'b0;

        if (i_VALID) begin
            case (state)
                SEARCH: begin
                    if (hit) begin
                        phase_n = hit_idx + 2'd1;
                        match_n = 8'd1;
                        miss_n  = 8'd0;
                        state_n = (LOCK_LIM == 8'd1) ? LOCKED : VERIFY;
                    end else if (miss_cnt + 8'd1 == SLIP_LIM) begin
                        slip_n = 1'b1;
                        miss_n = 8'd0;
                    end else begin
                        miss_n = miss_cnt + 8'd1;
                    end
                end
                VERIFY: begin
                    if (exp_match) begin
                        match_n = match_cnt + 8'd1;
                        phase_n = phase + 2'd1;
                        if (match_cnt + 8'd1 == LOCK_LIM)
                            state_n = LOCKED;
                    end else begin
                        state_n = SEARCH;
                        match_n = 8'd0;
                    end
                end
                LOCKED: begin
                    phase_n = phase + 2'd1;
                    if (exp_match) begin
                        err_run_n = 8'd0;
                    end else begin
                        err_n = 1'b1;
                        if (err_cnt != '1)
                            err_cnt_n = err_cnt + 1'b1;
                        if (err_run + 8'd1 == UNLOCK_LIM) begin
                            state_n   = SEARCH;
                            err_run_n = 8'd0;
                            match_n   = 8'd0;
                        end else begin
                            err_run_n = err_run + 8'd1;
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end

        // A clear beats a same-cycle increment; the o_ERR pulse still goes out.
        if (i_CLR_ERR)
            err_cnt_n = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state     <= SEARCH;
            phase     <= 2'd0;
            match_cnt <= 8'd0;
            miss_cnt  <= 8'd0;
            err_run   <= 8'd0;
            err_cnt   <= '0;
            o_ERR     <= 1'b0;
            o_SLIP    <= 1'b0;
            o_LOCKED  <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            err_run   <= err_run_n;
            err_cnt   <= err_cnt_n;
            o_ERR     <= err_n;
            o_SLIP    <= slip_n;
            o_LOCKED  <= (state_n == LOCKED);
        end
    end

    assign o_ERR_CNT = err_cnt;
    assign o_PHASE   = phase;

endmodule

// File: tb/tb_pattern0_checker.sv
// Self-checking bench for pattern0_checker with directed test-plan scenarios and a randomized stream.
// The random stream is scored against a word-by-word behavioural model.
module tb_pattern0_checker;

    localparam int LOCK_CNT   = 8;
    localparam int UNLOCK_ERR = 4;
    localparam int SLIP_WAIT  = 16;
    localparam int CNT_W      = 16;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic             i_CLK = 1'b0;
    logic             i_RST = 1'b1;
    logic [15:0]      i_DATA = 16'h0;
    logic             i_VALID = 1'b0;
    logic             i_CLR_ERR = 1'b0;
    logic             o_LOCKED, o_ERR, o_SLIP;
    logic [CNT_W-1:0] o_ERR_CNT;
    logic [1:0]       o_PHASE;

    pattern0_checker #(
        .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .SLIP_WAIT(SLIP_WAIT), .CNT_W(CNT_W)
    ) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_DATA(i_DATA), .i_VALID(i_VALID), .i_CLR_ERR(i_CLR_ERR),
        .o_LOCKED(o_LOCKED), .o_ERR(o_ERR), .o_ERR_CNT(o_ERR_CNT), .o_PHASE(o_PHASE), .o_SLIP(o_SLIP)
    );

    always #5 i_CLK = ~i_CLK;

    logic [15:0] pat [4] = '{16'hA6E2, 16'hF0A0, 16'h5CDB, 16'h475E};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    // Reference model: mode 0=hunting, 1=confirming, 2=locked.
    int  m_mode, m_phase, m_matches, m_misses, m_bad_run, m_errs;
    bit  m_err, m_slip;

    function automatic int which_pattern(input logic [15:0] d);
        for (int k = 0; k < 4; k++) if (d == pat[k]) return k;
        return -1;
    endfunction

    task automatic model(input logic [15:0] d, input bit v, input bit c, input bit r);
        int k;
        if (r) begin
            m_mode = 0; m_phase = 0; m_matches = 0; m_misses = 0;
            m_bad_run = 0; m_errs = 0; m_err = 0; m_slip = 0;
            return;
        end
        m_err = 0; m_slip = 0;
        if (v) begin
            if (m_mode == 0) begin
                k = which_pattern(d);
                if (k >= 0) begin
                    m_phase = (k + 1) % 4; m_matches = 1; m_misses = 0;
                    m_mode = (LOCK_CNT == 1) ? 2 : 1;
                end else begin
                    m_misses++;
                    if (m_misses == SLIP_WAIT) begin m_slip = 1; m_misses = 0; end
                end
            end else if (m_mode == 1) begin
                if (d == pat[m_phase]) begin
                    m_matches++; m_phase = (m_phase + 1) % 4;
                    if (m_matches == LOCK_CNT) m_mode = 2;
                end else begin
                    m_mode = 0; m_matches = 0;
                end
            end else begin
                if (d != pat[m_phase]) begin
                    m_err = 1; m_bad_run++;
                    if (m_errs < CNT_MAX) m_errs++;
                    if (m_bad_run == UNLOCK_ERR) begin m_mode = 0; m_bad_run = 0; m_matches = 0; end
                end else begin
                    m_bad_run = 0;
                end
                m_phase = (m_phase + 1) % 4;
            end
        end
        if (c) m_errs = 0;
    endtask

    task automatic step(input logic [15:0] d, input bit v, input bit c, input bit r);
        @(negedge i_CLK);
        i_DATA = d; i_VALID = v; i_CLR_ERR = c; i_RST = r;
        @(posedge i_CLK);
        model(d, v, c, r);
        #1;
        check("locked",  int'(o_LOCKED),  int'(m_mode == 2));
        check("err",     int'(o_ERR),     int'(m_err));
        check("err_cnt", int'(o_ERR_CNT), m_errs);
        check("phase",   int'(o_PHASE),   m_phase);
        check("slip",    int'(o_SLIP),    int'(m_slip));
    endtask

    task automatic do_reset();
        step(16'h0, 0, 0, 1);
        check("rst_locked",  int'(o_LOCKED),  0);
        check("rst_err_cnt", int'(o_ERR_CNT), 0);
        check("rst_phase",   int'(o_PHASE),   0);
    endtask

    int tx;
    int slips, locks;

    initial begin
        // Lock from phase 0.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(pat[i % 4], 1, 0, 0);
            if (i == 6) check("p0_not_yet", int'(o_LOCKED), 0);
            if (i == 7) check("p0_lock", int'(o_LOCKED), 1);
        end
        check("p0_phase", int'(o_PHASE), 0);

        // Lock from offset phase, starting at 5CDB.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(pat[(i + 2) % 4], 1, 0, 0);
            if (i == 1) check("off_phase0", int'(o_PHASE), 0);
            if (i == 6) check("off_not_yet", int'(o_LOCKED), 0);
        end
        check("off_lock", int'(o_LOCKED), 1);
        tx = 2;  // next expected word is 5CDB

        // Single error: keep sending until F0A0 is next, then corrupt it.
        while (tx != 1) begin step(pat[tx], 1, 0, 0); tx = (tx + 1) % 4; end
        step(16'h0000, 1, 0, 0); tx = 2;
        check("single_err", int'(o_ERR), 1);
        check("single_cnt", int'(o_ERR_CNT), 1);
        check("single_locked", int'(o_LOCKED), 1);
        step(pat[tx], 1, 0, 0); tx = 3;
        check("single_next_ok", int'(o_ERR), 0);

        // Loss of lock after four bad words, then relock with count retained.
        step(pat[tx], 1, 1, 0); tx = 0;
        check("clr", int'(o_ERR_CNT), 0);
        for (int i = 0; i < 4; i++) step(16'h0000, 1, 0, 0);
        check("lol_cnt", int'(o_ERR_CNT), 4);
        check("lol_unlocked", int'(o_LOCKED), 0);
        for (int i = 0; i < 8; i++) step(pat[i % 4], 1, 0, 0);
        check("relock", int'(o_LOCKED), 1);
        check("relock_cnt", int'(o_ERR_CNT), 4);

        // Clear colliding with a bad word.
        step(16'h1111, 1, 1, 0);
        check("clr_coll_cnt", int'(o_ERR_CNT), 0);
        check("clr_coll_err", int'(o_ERR), 1);

        // Reset while locked.
        do_reset();
        check("rst_mid_slip", int'(o_SLIP), 0);

        // Bitslip requests on a constant non-pattern stream.
        slips = 0; locks = 0;
        for (int i = 0; i < 64; i++) begin
            step(16'h1234, 1, 0, 0);
            slips += int'(o_SLIP); locks += int'(o_LOCKED);
            if (i == 14) check("slip_early", int'(o_SLIP), 0);
            if (i == 15) check("slip_16th", int'(o_SLIP), 1);
        end
        check("slip_count", slips, 4);
        check("slip_nolock", locks, 0);

        // Gapped variant: one slip per 32 cycles.
        do_reset();
        slips = 0;
        for (int i = 0; i < 64; i++) begin
            step(16'h1234, (i % 2) == 0, 0, 0);
            slips += int'(o_SLIP);
        end
        check("gap_slip_count", slips, 2);

        // Randomized stream: transmitter with random gaps, corruption, phase jumps, clears, rare resets.
        do_reset();
        tx = int'($urandom_range(0, 3));
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] d;
            bit v, c, r;
            int roll;
            roll = int'($urandom_range(0, 999));
            r = (roll < 2);
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 49) == 0);
            d = pat[tx];
            roll = int'($urandom_range(0, 99));
            if (roll < 6) d = 16'($urandom);
            else if (roll < 8) tx = int'($urandom_range(0, 3));
            if (roll >= 6 && roll < 8) d = pat[tx];
            step(d, v, c, r);
            if (v) tx = (tx + 1) % 4;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pattern0_checker.md
Name: pattern0_checker

Overview:
- Receive-side checker for the 4-word repeating 16-bit training pattern: A6E2, F0A0, 5CDB, 475E, then repeat.
- Sits after the deserializer and word-assembly logic on the link receive path.
- Finds the pattern phase, declares lock, and counts word errors while locked.
- Requests a bitslip from the deserializer when it cannot find any pattern word.

Parameters:
- LOCK_CNT, 8: consecutive in-sequence matching words needed to declare lock, counting the first search hit. Range 1..255.
- UNLOCK_ERR, 4: consecutive mismatching words while locked that force loss of lock. Range 1..255.
- SLIP_WAIT, 16: consecutive non-matching valid words in SEARCH before an o_SLIP pulse. Range 1..255.
- CNT_W, 16: width of the error counter.

Ports:
- i_CLK, input, 1: clock.
- i_RST, input, 1: synchronous, active-high reset.
- i_DATA, input, 16: received word.
- i_VALID, input, 1: i_DATA is valid this cycle.
- i_CLR_ERR, input, 1: synchronous clear of o_ERR_CNT.
- o_LOCKED, output, 1: pattern lock indication.
- o_ERR, output, 1: one-cycle pulse per mismatching word while locked.
- o_ERR_CNT, output, CNT_W: saturating count of errored words while locked.
- o_PHASE, output, 2: index of the next expected word (0=A6E2, 1=F0A0, 2=5CDB, 3=475E).
- o_SLIP, output, 1: one-cycle bitslip request to the deserializer.

Behaviour:
- Reset (i_RST=1 at a clock edge):
  - state=SEARCH.
  - All outputs 0.
  - match, miss, error-run and error counters 0; expected phase 0.
  - Reset takes priority over every other input, including mid-LOCKED operation.
- Registering and latency:
  - All outputs are registered.
  - The response to a word sampled at edge N appears after edge N, i.e. one cycle of latency.
- i_VALID=0:
  - No state, counter or phase change.
  - o_ERR and o_SLIP are 0 that cycle.
  - i_CLR_ERR is still honoured.
- Pattern table: S0=A6E2, S1=F0A0, S2=5CDB, S3=475E. Phase arithmetic is modulo 4, and 3 wraps to 0.
- SEARCH:
  - If a valid word equals some Sk:
    - expected phase = k+1;
    - match counter = 1;
    - miss counter = 0;
    - next state = LOCKED if LOCK_CNT==1, else VERIFY.
  - Otherwise, miss counter increments.
  - When the miss counter reaches SLIP_WAIT:
    - o_SLIP pulses for one cycle;
    - the miss counter returns to 0;
    - o_SLIP is never asserted outside SEARCH.
  - o_PHASE is held in SEARCH.
- VERIFY:
  - If a valid word equals S[expected]:
    - match counter increments;
    - phase increments;
    - when the match counter reaches LOCK_CNT, go to LOCKED, and o_LOCKED rises on the same edge.
  - If a valid word mismatches:
    - go to SEARCH and clear the match counter;
    - the mismatching word is not re-evaluated as a search candidate;
    - no o_ERR, and o_ERR_CNT is unchanged.
- LOCKED:
  - Each valid word is compared with S[expected]. The phase advances on every valid word, matching or not.
  - Mismatch:
    - o_ERR pulses;
    - o_ERR_CNT increments, saturating at all-ones;
    - error-run counter increments.
  - Match: error-run counter is cleared to 0.
  - When the error-run counter reaches UNLOCK_ERR:
    - go to SEARCH on the same edge;
    - o_LOCKED falls;
    - the error run and match counter are cleared;
    - o_ERR_CNT is retained.
- i_CLR_ERR:
  - Sets o_ERR_CNT to 0 on that edge.
  - If asserted in the same cycle as an errored word, the clear wins: the counter becomes 0, but o_ERR still pulses.
- The reset-then-clean-stream case is handled by the same rules; no special-casing is needed.

Test Plan:
- Lock from phase 0:
  - Stimulus: reset, then continuous valid stream A6E2, F0A0, 5CDB, 475E, ... with default parameters.
  - Response: o_LOCKED=1 from the cycle after the 8th word; o_ERR_CNT stays 0; o_SLIP never pulses; o_PHASE equals the index of the next word.
- Lock from an offset phase:
  - Stimulus: stream starting at 5CDB.
  - Response: lock after the 8th word, same latency as phase 0; o_PHASE=0 after the 2nd word, since the next expected word is A6E2.
- Single error while locked:
  - Stimulus: replace one F0A0 with 0000.
  - Response: a single o_ERR pulse; o_ERR_CNT=1; o_LOCKED stays 1; the following 5CDB matches with no further error.
- Loss of lock:
  - Stimulus: while locked, 4 consecutive corrupted words.
  - Response: o_ERR_CNT=4; o_LOCKED falls after the 4th bad word. A clean stream then relocks after 8 words and o_ERR_CNT remains 4.
- Bitslip request:
  - Stimulus: constant 1234 stream from reset.
  - Response: o_SLIP pulses once every 16 valid words; never locks.
  - Gapped variant: with i_VALID toggling 1/0, o_SLIP pulses every 16 valid words, i.e. 32 cycles.
- Clear collision and reset mid-lock:
  - Stimulus: while locked, assert i_CLR_ERR in the same cycle as a bad word.
  - Response: o_ERR_CNT=0 and o_ERR pulses.
  - Stimulus: assert i_RST while locked.
  - Response: all outputs 0 and state SEARCH on the next cycle.
